// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M/RV64M multiply/divide unit, one bit per cycle, valid/ready in and out
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            In_Valid,
  output logic            In_Ready,
  input  logic [2:0]      MDControl,
  input  logic [XLEN-1:0] Src_A,
  input  logic [XLEN-1:0] Src_B,
  input  logic            Flush,
  output logic            Out_Valid,
  input  logic            Out_Ready,
  output logic [XLEN-1:0] Result,
  output logic            DivZero
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op;
  logic [XLEN-1:0] a_mag, b_mag, amag_in, bmag_in, special_res, fin;
  logic [2*XLEN-1:0] prod, step, full;
  logic [CNT_W-1:0] cnt;
  logic neg_q, neg_r, accept, sa, sb, na, nb, dz, ovf, special;
  logic [XLEN:0] msum, shifted, diff;
  always_comb begin
    accept = In_Valid && state == IDLE && !Flush;
    sa = MDControl inside {3'b001, 3'b010, 3'b100, 3'b110};
    sb = MDControl inside {3'b001, 3'b100, 3'b110};
    na = sa && Src_A[XLEN-1];
    nb = sb && Src_B[XLEN-1];
    amag_in = na ? -Src_A : Src_A;
    bmag_in = nb ? -Src_B : Src_B;
    dz = MDControl[2] && Src_B == '0;
    ovf = MDControl[2] && !MDControl[0] && Src_A == {1'b1, {(XLEN-1){1'b0}}} && &Src_B;
    special = dz || ovf;
    special_res = dz ? (MDControl[1] ? Src_A : '1) : (MDControl[1] ? '0 : Src_A);
    // product high half doubles as remainder, low half as multiplier / dividend-quotient shifter
    msum = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, prod[0] ? a_mag : {XLEN{1'b0}}};
    shifted = prod[2*XLEN-1:XLEN-1];
    diff = shifted - {1'b0, b_mag};
    step = op[2] ? {diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0], prod[XLEN-2:0], ~diff[XLEN]}
                 : {msum, prod[XLEN-1:1]};
    full = neg_q ? -prod : prod;
    fin = op[2] ? (op[1] ? (neg_r ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN])
                         : (neg_q ? -prod[XLEN-1:0] : prod[XLEN-1:0]))
                : (op[1:0] == 2'b00 ? full[XLEN-1:0] : full[2*XLEN-1:XLEN]);
    state_n = state == IDLE ? (accept ? (special ? DONE : CALC) : IDLE)
            : state == CALC ? (Flush ? IDLE : (cnt == '0 ? DONE : CALC))
            : (Flush || Out_Ready ? IDLE : DONE);
  end
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op <= '0;
      a_mag <= '0;
      b_mag <= '0;
      prod <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      Result <= '0;
      DivZero <= 1'b0;
    end else if (accept) begin
      op <= MDControl;
      a_mag <= amag_in;
      b_mag <= bmag_in;
      prod <= {{XLEN{1'b0}}, MDControl[2] ? amag_in : bmag_in};
      cnt <= CNT_W'(XLEN);
      neg_q <= na ^ nb;
      neg_r <= na;
      if (special) begin
        Result <= special_res;
        DivZero <= dz;
      end
    end else if (state == CALC && !Flush) begin
      if (cnt != '0) begin
        prod <= step;
        cnt <= cnt - 1'b1;
      end else begin
        Result <= fin;
        DivZero <= 1'b0;
      end
    end
  end
  assign In_Ready = state == IDLE;
  assign Out_Valid = state == DONE;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed and random checks of alu_muldiv against a plain-arithmetic model
module tb_alu_muldiv;
  logic clk = 0, reset_n = 0, In_Valid = 0, In_Ready, Flush = 0, Out_Valid, Out_Ready = 0, DivZero;
  logic [2:0] MDControl = 0;
  logic [31:0] Src_A = 0, Src_B = 0, Result;
  int total = 0, bad = 0;
  alu_muldiv #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .In_Valid(In_Valid), .In_Ready(In_Ready), .MDControl(MDControl),
    .Src_A(Src_A), .Src_B(Src_B), .Flush(Flush), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Result(Result), .DivZero(DivZero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic dz, output logic sp);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    dz = op[2] && b == 0;
    ov = (op == 4 || op == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    sp = dz || ov;
    p = 0;
    r = 0;
    case (op)
      0: begin p = ua * ub; r = p[31:0]; end
      1: begin p = sa * sb; r = p[63:32]; end
      2: begin p = sa * ub; r = p[63:32]; end
      3: begin p = ua * ub; r = p[63:32]; end
      4: r = b == 0 ? 32'hFFFF_FFFF : ov ? a : 32'(sa / sb);
      5: r = b == 0 ? 32'hFFFF_FFFF : 32'(ua / ub);
      6: r = b == 0 ? a : ov ? 32'h0 : 32'(sa % sb);
      default: r = b == 0 ? a : 32'(ua % ub);
    endcase
  endtask
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic ed, sp;
    int n;
    model(op, a, b, er, ed, sp);
    @(negedge clk);
    In_Valid = 1; MDControl = op; Src_A = a; Src_B = b;
    chk("in_ready_idle", In_Ready, 1);
    @(posedge clk); #1;
    In_Valid = 0; MDControl = 3'($urandom); Src_A = $urandom; Src_B = $urandom;
    n = 0;
    while (!Out_Valid && n < 100) begin
      if (n == 5) chk("in_ready_busy", In_Ready, 0);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, sp ? 0 : 33);
    chk("result", Result, er);
    chk("divzero", DivZero, ed);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", Out_Valid, 1);
      chk("hold_result", Result, er);
      chk("hold_divzero", DivZero, ed);
      chk("hold_in_ready", In_Ready, 0);
    end
    Out_Ready = 1;
    @(posedge clk); #1;
    Out_Ready = 0;
    chk("valid_drop", Out_Valid, 0);
    chk("idle_ready", In_Ready, 1);
    chk("result_kept", Result, er);
  endtask
  task automatic start_and_wait(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int edges);
    @(negedge clk);
    In_Valid = 1; MDControl = op; Src_A = a; Src_B = b;
    @(posedge clk); #1;
    In_Valid = 0;
    for (int i = 0; i < edges; i++) begin @(posedge clk); #1; end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", In_Ready, 1);
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_result", Result, 0);
    chk("rst_divzero", DivZero, 0);
    @(negedge clk) reset_n = 1;
    run(0, 7, 32'hFFFF_FFFD, 0);
    run(1, 32'h8000_0000, 32'h8000_0000, 0);
    run(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(0, 32'h1234_5678, 0, 0);
    run(4, 32'hFFFF_FFF9, 2, 0);
    run(6, 32'hFFFF_FFF9, 2, 0);
    run(5, 100, 7, 0);
    run(7, 100, 7, 0);
    run(4, 5, 0, 0);
    run(7, 5, 0, 0);
    run(4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(1, 32'hDEAD_BEEF, 32'h1234_5678, 5);
    run(5, 32'hFFFF_FFFF, 3, 0);
    for (int i = 0; i < 160; i++) begin
      logic [31:0] a, b;
      a = $urandom_range(0, 5) == 0 ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run(3'($urandom), a, b, $urandom_range(0, 2));
    end
    start_and_wait(0, 32'h0BAD_F00D, 32'h0000_1234, 10);
    @(negedge clk) reset_n = 0;
    @(posedge clk); #1;
    chk("abort_rst_valid", Out_Valid, 0);
    chk("abort_rst_ready", In_Ready, 1);
    chk("abort_rst_result", Result, 0);
    @(negedge clk) reset_n = 1;
    start_and_wait(5, 32'h0001_0000, 3, 10);
    @(negedge clk) Flush = 1;
    @(posedge clk); #1;
    Flush = 0;
    chk("flush_calc_ready", In_Ready, 1);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_calc_no_result", Out_Valid, 0);
    start_and_wait(4, 9, 0, 0);
    chk("flush_done_pre", Out_Valid, 1);
    @(negedge clk);
    Flush = 1; Out_Ready = 1;
    @(posedge clk); #1;
    Flush = 0; Out_Ready = 0;
    chk("flush_done_valid", Out_Valid, 0);
    chk("flush_done_ready", In_Ready, 1);
    @(negedge clk);
    Flush = 1; In_Valid = 1; MDControl = 0; Src_A = 1; Src_B = 1;
    @(posedge clk); #1;
    Flush = 0; In_Valid = 0;
    chk("flush_blocks_accept", In_Ready, 1);
    run(0, 3, 4, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
